// File: rtl/jtgng_sdram_slots.sv
`default_nettype none
// ============================================================================
// jtgng_sdram_slots : round-robin ROM read arbiter for the shared SDRAM port
// Rev 1.0
// ============================================================================
module jtgng_sdram_slots #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [DW-1:0]       slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [DW-1:0]       data_read,
  input  logic                refresh_req,
  output logic                autorefresh,
  output logic                busy
);

  localparam int               GW       = $clog2(SLOTS);
  localparam logic [GW-1:0]    LAST_IDX = GW'(SLOTS - 1);
  localparam logic [SLOTS-1:0] ONE_HOT0 = SLOTS'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, next_state;
  logic [GW-1:0] last, grant, pick, idx;
  logic          found, do_grant, do_refresh, ref_flag;
  logic [AW-1:0] addr_arr [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_unpack
    assign addr_arr[i] = slot_addr[i*AW +: AW];
  end

  // Search starts one past the last winner; explicit wrap keeps non-power-of-two counts correct
  always_comb begin
    pick  = last;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < SLOTS; k++) begin
      idx = (idx == LAST_IDX) ? '0 : idx + GW'(1);
      if (!found && slot_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    do_grant   = 1'b0;
    do_refresh = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_req && !ref_flag) begin
          do_refresh = 1'b1;
        end else if (!downloading && found) begin
          do_grant   = 1'b1;
          next_state = ISSUE;
        end else if (refresh_req) begin
          do_refresh = 1'b1;
        end
      end
      ISSUE:   if (sdram_ack) next_state = WAIT;
      WAIT:    if (sdram_rdy) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= LAST_IDX;
      grant       <= '0;
      ref_flag    <= 1'b0;
      sdram_req   <= 1'b0;
      sdram_addr  <= '0;
      slot_ok     <= '0;
      slot_dout   <= '0;
      autorefresh <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy        <= (next_state != IDLE);
      autorefresh <= do_refresh;
      slot_ok     <= '0;
      // Alternation flag only tracks IDLE decisions, so it survives a transaction
      if (state == IDLE) ref_flag <= do_refresh;
      if (do_grant) begin
        grant      <= pick;
        last       <= pick;
        sdram_addr <= addr_arr[pick];
        sdram_req  <= 1'b1;
      end
      if (state == ISSUE && sdram_ack) sdram_req <= 1'b0;
      if (state == WAIT && sdram_rdy) begin
        slot_dout <= data_read;
        slot_ok   <= ONE_HOT0 << grant;
      end
    end
  end

endmodule
`default_nettype wire
